// File: rtl/alu_exec_unit.sv
// Registered ALU execution stage: single-cycle add/sub/and/or/slt, plus a
// WIDTH-cycle shift-add multiply with a start/busy/done handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       AluOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_sum;
  logic             slt;

  assign slt = $signed(A) < $signed(B);

  always_comb begin
    alu_res = '0;
    unique case (AluOperation)
      3'b000:  alu_res = A + B;
      3'b001:  alu_res = A - B;
      3'b010:  alu_res = A & B;
      3'b011:  alu_res = A | B;
      3'b111:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = '0; // 101/110 reserved; 100 never takes this path
    endcase
  end

  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (AluOperation == OP_MUL) begin
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Final iteration commits the sum including this cycle's partial product
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = mul_sum;
          zero_d   = (mul_sum == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = (state_q == MUL);
  assign done   = done_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32) with hand-computed expectations.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    AluOperation = 3'b000;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [W-1:0]  result;
  logic          zero, busy, done;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .AluOperation(AluOperation),
    .A(A), .B(B), .result(result), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Present an op before the next rising edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; AluOperation = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || result !== 32'd0) begin bad++; $display("FAIL post_release got done=%b result=%h exp done=0 result=0", done, result); end
  endtask

  task automatic test_add;
    issue(3'b000, 32'd5, 32'd7);
    total++; if (result !== 32'd12) begin bad++; $display("FAIL add_result got=%h exp=c", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%b exp=0", zero); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL add_done got=%b exp=1", done); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_fall got=%b exp=0", done); end
    total++; if (result !== 32'd12) begin bad++; $display("FAIL add_hold got=%h exp=c", result); end
  endtask

  task automatic test_arith_edges;
    issue(3'b001, 32'd3, 32'd3);
    total++; if (result !== 32'd0 || zero !== 1'b1) begin bad++; $display("FAIL sub_eq got=%h/%b exp=0/1", result, zero); end
    issue(3'b000, 32'hFFFF_FFFF, 32'd1);
    total++; if (result !== 32'd0 || zero !== 1'b1) begin bad++; $display("FAIL add_wrap got=%h/%b exp=0/1", result, zero); end
    issue(3'b111, 32'hFFFF_FFFF, 32'd1);
    total++; if (result !== 32'd1 || zero !== 1'b0) begin bad++; $display("FAIL slt_neg got=%h/%b exp=1/0", result, zero); end
    issue(3'b111, 32'd1, 32'hFFFF_FFFF);
    total++; if (result !== 32'd0 || zero !== 1'b1) begin bad++; $display("FAIL slt_pos got=%h/%b exp=0/1", result, zero); end
    issue(3'b001, 32'd2, 32'd5);
    total++; if (result !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sub_wrap got=%h exp=fffffffd", result); end
  endtask

  task automatic test_logic_reserved;
    issue(3'b010, 32'h0000_F0F0, 32'h0000_FF00);
    total++; if (result !== 32'h0000_F000) begin bad++; $display("FAIL and got=%h exp=f000", result); end
    issue(3'b011, 32'h0000_F0F0, 32'h0000_FF00);
    total++; if (result !== 32'h0000_FFF0) begin bad++; $display("FAIL or got=%h exp=fff0", result); end
    issue(3'b101, 32'h1234_5678, 32'h1);
    total++; if (result !== 32'd0 || zero !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL rsv101 got=%h/%b/%b exp=0/1/1", result, zero, done); end
    issue(3'b011, 32'h5, 32'h0);
    issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if (result !== 32'd0 || zero !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rsv110 got=%h/%b/%b/%b exp=0/1/1/0", result, zero, done, busy); end
  endtask

  // Runs a multiply and returns the number of busy samples; optionally pokes
  // start/operands while busy. Returns #1 after the completion edge.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise, output int nbusy);
    logic [W-1:0] prev;
    prev = result;
    issue(3'b100, a, b);
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      total++; if (done !== 1'b0 || result !== prev) begin bad++; $display("FAIL mul_hold got done=%b result=%h exp done=0 result=%h", done, result, prev); end
      if (noise) begin
        start = 1'b1; AluOperation = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_mul;
    int n;
    run_mul(32'd1234, 32'd5678, 1'b1, n);
    total++; if (n !== 32) begin bad++; $display("FAIL mul_busy_len got=%0d exp=32", n); end
    total++; if (result !== 32'd7006652 || zero !== 1'b0) begin bad++; $display("FAIL mul_result got=%0d exp=7006652", result); end
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mul_done got done=%b busy=%b exp 1/0", done, busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_fall got=%b exp=0", done); end
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n);
    total++; if (result !== 32'd1 || done !== 1'b1 || n !== 32) begin bad++; $display("FAIL mul_ones got=%h done=%b n=%0d exp=1/1/32", result, done, n); end
    run_mul(32'h8000_0000, 32'd2, 1'b0, n);
    total++; if (result !== 32'd0 || zero !== 1'b1) begin bad++; $display("FAIL mul_overflow got=%h/%b exp=0/1", result, zero); end
  endtask

  task automatic test_back_to_back;
    int n;
    run_mul(32'd6, 32'd7, 1'b0, n);
    total++; if (result !== 32'd42 || done !== 1'b1) begin bad++; $display("FAIL b2b_mul got=%0d done=%b exp 42/1", result, done); end
    start = 1'b1; AluOperation = 3'b000; A = 32'd1; B = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (result !== 32'd2 || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_add got=%0d done=%b busy=%b exp 2/1/0", result, done, busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_fall got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    issue(3'b100, 32'd6, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++; if (result !== 32'd0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset got=%h/%b/%b/%b exp=0/1/0/0", result, zero, busy, done); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL no_done_after_abort got=%0d exp=0", seen); end
    issue(3'b001, 32'd10, 32'd4);
    total++; if (result !== 32'd6 || done !== 1'b1) begin bad++; $display("FAIL sub_after_reset got=%0d done=%b exp 6/1", result, done); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_arith_edges;
    test_logic_reserved;
    test_mul;
    test_back_to_back;
    test_reset_mid_mul;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execution stage that consumes the 3-bit `AluOperation` code produced by the ALU controller, together with two operands from the register file and immediate path, and returns a result plus zero flag. Single-cycle operations complete in one clock. Code `3'b100` is a sequential shift-add multiply that takes `WIDTH` cycles. A start/busy/done handshake lets the core stall on multi-cycle operations.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request; sampled only when an operation can be accepted.
- `AluOperation`, input, 3: operation code.
- `A`, input, `WIDTH`: operand A, captured when `start` is accepted.
- `B`, input, `WIDTH`: operand B, captured when `start` is accepted.
- `result`, output, `WIDTH`: registered result; holds until the next completion.
- `zero`, output, 1: registered, equal to (`result` == 0); updates together with `result`.
- `busy`, output, 1: multiply in progress.
- `done`, output, 1: one-cycle pulse when `result` is valid.

## Operation
- Operation codes:
  - 000: `A+B`, modulo 2^WIDTH.
  - 001: `A-B`, modulo 2^WIDTH.
  - 010: `A&B`.
  - 011: `A|B`.
  - 111: slt, where `result` = {0…, ($signed(A) < $signed(B))}.
  - 100: multiply, where `result` = low `WIDTH` bits of `A*B`.
  - 101 and 110: reserved; `result` = 0, `zero` = 1, treated as single-cycle.
- Overflow and carry are not reported.
- State machine has two states, IDLE and MUL.
  - IDLE: `start`=1 is accepted.
    - Single-cycle code: compute from live `A`/`B`, write `result`/`zero`, pulse `done`, stay in IDLE.
    - Code 100: load the multiplicand register with `A` and the multiplier register with `B`, clear the accumulator and the iteration counter (`$clog2(WIDTH)+1` bits), go to MUL.
  - MUL: each cycle:
    - If multiplier LSB = 1, add the multiplicand to the accumulator.
    - Shift the multiplicand left by 1 and the multiplier right by 1.
    - Increment the counter.
    - On the iteration where counter = `WIDTH-1`, write the final accumulator to `result`/`zero`, pulse `done`, return to IDLE.
- `start` while in MUL is ignored. `A`, `B` and `AluOperation` may change freely during MUL.
- Reset, asserted at any time including mid-multiply:
  - Aborts immediately and forces IDLE.
  - Clears `result`=0, `zero`=1, `busy`=0, `done`=0, and all internal registers.
  - No `done` is produced for the aborted operation.

## Timing
- Reset values: `result`=0, `zero`=1, `busy`=0, `done`=0, state IDLE.
- Single-cycle op accepted at edge k: `result`/`zero` valid and `done`=1 during cycle k→k+1. `done` falls at edge k+1 unless a new single-cycle op is accepted at that edge, in which case `done` stays high.
- Multiply accepted at edge k:
  - `busy`=1 from edge k through edge k+WIDTH.
  - Iterations run at edges k+1 … k+WIDTH.
  - At edge k+WIDTH: `result` is written, `done`=1, `busy`=0.
  - Latency is `WIDTH` cycles after acceptance.
- Back-to-back: a new `start` is accepted in the cycle `done`=1 (state is IDLE). No bubble is required.
- `result` is not disturbed during MUL; it holds the previous value until completion.
- `busy` and `done` are never 1 in the same cycle.

## Test plan
- Reset release → `result`=0, `zero`=1, `busy`=0, `done`=0. Then add `A`=5, `B`=7 → `result`=12, `zero`=0, `done` for 1 cycle.
- Arithmetic edges:
  - sub `A`=3, `B`=3 → `result`=0, `zero`=1.
  - add `A`=0xFFFFFFFF, `B`=1 → `result`=0, `zero`=1 (wrap).
  - slt `A`=0xFFFFFFFF (−1), `B`=1 → `result`=1.
  - slt `A`=1, `B`=0xFFFFFFFF → `result`=0.
- Logic and reserved codes:
  - and `A`=0xF0F0, `B`=0xFF00 → 0xF000.
  - or → 0xFFF0.
  - codes 101 and 110 → `result`=0, `zero`=1, `done` after 1 cycle.
- Multiply:
  - `A`=1234, `B`=5678 → `busy` for exactly 32 cycles, then `result`=7006652, `done` pulse.
  - `A`=0xFFFFFFFF, `B`=0xFFFFFFFF → `result`=1.
  - `start` pulses and operand changes during `busy` have no effect.
- Back-to-back: multiply 6×7, then add 1+1 issued in the `done` cycle → `result`=42, then `result`=2 one cycle later, with `done` high in both cycles.
- Reset mid-multiply, asserted at iteration 10 → immediate `result`=0, `busy`=0, no `done`. After release, sub 10−4 → `result`=6.
